mvm3_requant: RTL
=================

MVM3_REQUANT -- requirements
Module: mvm3_requant

Interface
REQ-001 Parameter: SHIFT, default 4, arithmetic right-shift amount applied to each 16-bit result (legal 0..8).
REQ-002 Parameter: DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: s_valid  input  1  upstream result word valid.
REQ-006 Port: s_ready  output  1  block can accept a word this cycle.
REQ-007 Port: data_in  input  16  signed matrix-vector result element from the upstream MAC stage.
REQ-008 Port: relu_en  input  1  quasi-static config; 1 = clamp negatives to zero before shifting.
REQ-009 Port: m_valid  output  1  output byte valid.
REQ-010 Port: m_ready  input  1  downstream accepts output byte.
REQ-011 Port: data_out  output  8  signed requantised element.
REQ-012 Port: m_last  output  1  high with the third element of each 3-element result vector.
REQ-013 Port: sat_count  output  8  number of elements saturated since reset, sticky at 255.

Function
REQ-014 Transfer occurs on a rising edge where valid and ready are both high, per port; no other edge transfers data.
REQ-015 s_ready shall equal (FIFO occupancy < DEPTH), derived from registered state only, never from s_valid or m_ready.
REQ-016 Push when full shall not occur even if a pop happens the same cycle; s_ready stays low until occupancy drops.
REQ-017 Datapath per accepted word, combinational before FIFO write: x = (relu_en && data_in<0) ? 0 : data_in.
REQ-018 Rounding: if SHIFT>0, y = (x + 2^(SHIFT-1)) >>> SHIFT computed at 17+ bits (no overflow); if SHIFT=0, y = x.
REQ-019 Saturation: data = 127 if y>127, -128 if y<-128, else y[7:0]; sat flag = clamp occurred.
REQ-020 ReLU zeroing shall not count as saturation.
REQ-021 Element index counter: 2-bit, 0->1->2->0, advances on each input transfer; FIFO entry stores {last = (index==2), data} (9 bits).
REQ-022 sat_count increments by 1 on each input transfer with sat flag, holds at 255.
REQ-023 Latency: word accepted at edge N appears at FIFO head with m_valid high in the cycle after edge N when FIFO was empty.
REQ-024 m_valid = occupancy>0; data_out/m_last = head entry when m_valid, else 0.
REQ-025 Simultaneous push and pop (not full, not empty): occupancy unchanged, both pointers advance.
REQ-026 Head held stable while m_valid && !m_ready; m_valid never deasserts without a pop.
REQ-027 Read/write pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-028 FIFO preserves strict order; no reordering or drop.

Reset
REQ-029 Asserting reset at any time immediately clears occupancy, pointers, element index, sat_count to 0; in-flight and buffered data discarded.
REQ-030 During reset: m_valid=0, m_last=0, data_out=0, sat_count=0, s_ready=0.
REQ-031 First edge after reset deassertion: s_ready=1, element index starts at 0.

Verification
REQ-032 SHIFT=4, relu_en=0, push 100, -1000, 3000 -> outputs 6, -62, 127 with m_last=0,0,1; sat_count=1.
REQ-033 SHIFT=4, push -5000 then -50 with relu_en=1 -> outputs 0, 0; sat_count=0; with relu_en=0 -> -128, -3; sat_count=1.
REQ-034 m_ready=0, push 5 words with DEPTH=4 -> s_ready low after 4th transfer, 5th held; release m_ready -> 5 outputs in order, m_last on 3rd.
REQ-035 Continuous s_valid and m_ready high -> one transfer per cycle each side, occupancy stays 1, 1-cycle latency.
REQ-036 Assert reset with 3 entries buffered and element index 2 -> m_valid=0 at once; after release next input gets m_last=0 pattern restarting at index 0.
REQ-037 Push 300 saturating words -> sat_count reaches 255 and holds.

Source files
------------

// File: rtl/mvm3_requant_if.sv
// mvm3_requant_if: input word stream and output byte stream of mvm3_requant.
interface mvm3_requant_if;
    logic s_valid;
    logic s_ready;
    logic signed [15:0] data_in;
    logic m_valid;
    logic m_ready;
    logic signed [7:0] data_out;
    logic m_last;
    modport slave (input s_valid, data_in, m_ready, output s_ready, m_valid, data_out, m_last);
    modport master (output s_valid, data_in, m_ready, input s_ready, m_valid, data_out, m_last);
endinterface

// File: rtl/mvm3_requant.sv
// mvm3_requant: ReLU, round-shift and saturate 16-bit MVM results into a byte FIFO tagging every third element.
module mvm3_requant #(
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               relu_en,
    mvm3_requant_if.slave      io,
    output logic [7:0]         sat_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic signed [16:0] RND = (SHIFT == 0) ? 17'sd0 : 17'sd1 <<< (SHIFT == 0 ? 0 : SHIFT - 1);

    logic [8:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [1:0] idx;
    logic signed [16:0] x, y;
    logic signed [7:0] q;
    logic sat, push, pop;

    // 17-bit working width keeps the rounding add from overflowing
    always_comb begin
        x = (relu_en && io.data_in[15]) ? 17'sd0 : {io.data_in[15], io.data_in};
        y = (x + RND) >>> SHIFT;
        sat = (y > 17'sd127) || (y < -17'sd128);
        q = (y > 17'sd127) ? 8'sd127 : (y < -17'sd128) ? -8'sd128 : y[7:0];
    end

    assign io.s_ready = !reset && (count < FULL);
    assign io.m_valid = count != '0;
    assign io.data_out = io.m_valid ? mem[rptr][7:0] : 8'sd0;
    assign io.m_last = io.m_valid && mem[rptr][8];
    assign push = io.s_valid && io.s_ready;
    assign pop = io.m_valid && io.m_ready;

    always_ff @(posedge clk)
        if (push) mem[wptr] <= {idx == 2'd2, q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            idx <= '0;
            sat_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                if (sat && sat_count != 8'hff) sat_count <= sat_count + 8'd1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule
